// File: rtl/pipeline_sequencer.sv
// Central pipeline control for one core: advance strobe, per-register flush/enable
// generation, cache-hit synchronisation, load-use bubbles, MEM redirects and halt.
module pipeline_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             MemRead_MEM,
    input  logic             MemWr_MEM,
    input  logic             MemRead_EX,
    input  logic [4:0]       wsel_EX,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic             use_rs1_ID,
    input  logic             use_rs2_ID,
    input  logic             redirect_MEM,
    input  logic             is_halt_MEM,
    output logic             pipeline_ctrl,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             pc_sel_redirect,
    output logic             flush_IF_ID,
    output logic             flush_ID_EX,
    output logic             flush_EX_MEM,
    output logic             halt,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        IDONE  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t state, next_state;
    logic   d_req, d_ok, i_ok, load_use;

    assign d_req = MemRead_MEM | MemWr_MEM;
    assign d_ok  = !d_req | dhit;
    // IDONE remembers an ihit that arrived while the data side was still busy.
    assign i_ok  = ihit | (state == IDONE);
    assign pipeline_ctrl = i_ok & d_ok & (state != HALTED);

    assign load_use = MemRead_EX && (wsel_EX != 5'd0) &&
                      ((use_rs1_ID && (rs1_ID == wsel_EX)) ||
                       (use_rs2_ID && (rs2_ID == wsel_EX)));

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        next_state      = state;
        pc_en           = 1'b0;
        ifid_en         = 1'b0;
        pc_sel_redirect = 1'b0;
        flush_IF_ID     = 1'b0;
        flush_ID_EX     = 1'b0;
        flush_EX_MEM    = 1'b0;

        case (state)
            FETCH, IDONE: begin
                if (pipeline_ctrl)
                    next_state = is_halt_MEM ? HALTED : FETCH;
                else if (ihit)
                    next_state = IDONE;
            end
            HALTED:  next_state = HALTED;
            default: next_state = FETCH;
        endcase

        if (pipeline_ctrl) begin
            if (is_halt_MEM) begin
                flush_IF_ID  = 1'b1;
                flush_ID_EX  = 1'b1;
                flush_EX_MEM = 1'b1;
            end else if (redirect_MEM) begin
                pc_sel_redirect = 1'b1;
                pc_en           = 1'b1;
                ifid_en         = 1'b1;
                flush_IF_ID     = 1'b1;
                flush_ID_EX     = 1'b1;
                flush_EX_MEM    = 1'b1;
            end else if (load_use) begin
                // Freeze PC and IF/ID, inject one bubble into ID/EX.
                flush_ID_EX = 1'b1;
            end else begin
                pc_en   = 1'b1;
                ifid_en = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= FETCH;
            halt        <= 1'b0;
            cycle_count <= '0;
            stall_count <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state <= next_state;
            halt  <= (next_state == HALTED);
            if (state != HALTED) begin
                if (cycle_count != '1)
                    cycle_count <= cycle_count + CNT_W'(1);
                if (!pipeline_ctrl && (stall_count != '1))
                    stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed scenarios plus randomized
// stimulus compared against a rule-level reference model.
module tb_pipeline_sequencer;

    localparam int CNT_W = 6;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             nRST;
    logic             ihit, dhit, MemRead_MEM, MemWr_MEM, MemRead_EX;
    logic [4:0]       wsel_EX, rs1_ID, rs2_ID;
    logic             use_rs1_ID, use_rs2_ID, redirect_MEM, is_halt_MEM;
    logic             pipeline_ctrl, pc_en, ifid_en, pc_sel_redirect;
    logic             flush_IF_ID, flush_ID_EX, flush_EX_MEM, halt;
    logic [CNT_W-1:0] cycle_count, stall_count;

    pipeline_sequencer #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .MemRead_MEM(MemRead_MEM), .MemWr_MEM(MemWr_MEM), .MemRead_EX(MemRead_EX),
        .wsel_EX(wsel_EX), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID),
        .redirect_MEM(redirect_MEM), .is_halt_MEM(is_halt_MEM),
        .pipeline_ctrl(pipeline_ctrl), .pc_en(pc_en), .ifid_en(ifid_en),
        .pc_sel_redirect(pc_sel_redirect), .flush_IF_ID(flush_IF_ID),
        .flush_ID_EX(flush_ID_EX), .flush_EX_MEM(flush_EX_MEM), .halt(halt),
        .cycle_count(cycle_count), .stall_count(stall_count)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       ihit, dhit, mr_mem, mw_mem, mr_ex;
        logic [4:0] wsel, rs1, rs2;
        logic       u1, u2, redir, halt_m;
    } stim_t;

    // Order: {pipeline_ctrl, pc_en, ifid_en, pc_sel_redirect, flush_IF_ID, flush_ID_EX, flush_EX_MEM, halt}
    wire [7:0] obs = {pipeline_ctrl, pc_en, ifid_en, pc_sel_redirect,
                      flush_IF_ID, flush_ID_EX, flush_EX_MEM, halt};

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: "instruction fetched, waiting on data" flag, halted flag, counts.
    bit m_ifetched, m_halted;
    int m_cycle, m_stall;

    function automatic bit model_adv(input stim_t s);
        return !m_halted && (s.ihit || m_ifetched) && (!(s.mr_mem || s.mw_mem) || s.dhit);
    endfunction

    function automatic logic [7:0] model_out(input stim_t s);
        bit lu;
        lu = s.mr_ex && (s.wsel != 0) &&
             ((s.u1 && s.rs1 == s.wsel) || (s.u2 && s.rs2 == s.wsel));
        if (!model_adv(s))  return {7'b0000000, m_halted};
        else if (s.halt_m)  return 8'b1000_1110;
        else if (s.redir)   return 8'b1111_1110;
        else if (lu)        return 8'b1000_0100;
        else                return 8'b1110_0000;
    endfunction

    // IF/ID enable on the halting advance is left to the implementation.
    function automatic logic [7:0] model_mask(input stim_t s);
        return (model_adv(s) && s.halt_m) ? 8'b1101_1111 : 8'hFF;
    endfunction

    task automatic model_clock(input stim_t s);
        bit adv;
        adv = model_adv(s);
        if (!m_halted) begin
            if (m_cycle < CMAX) m_cycle++;
            if (!adv && m_stall < CMAX) m_stall++;
            if (adv) begin
                m_ifetched = 0;
                if (s.halt_m) m_halted = 1;
            end else if (s.ihit) begin
                m_ifetched = 1;
            end
        end
    endtask

    task automatic model_reset();
        m_ifetched = 0; m_halted = 0; m_cycle = 0; m_stall = 0;
    endtask

    task automatic drive(input stim_t s);
        ihit = s.ihit; dhit = s.dhit; MemRead_MEM = s.mr_mem; MemWr_MEM = s.mw_mem;
        MemRead_EX = s.mr_ex; wsel_EX = s.wsel; rs1_ID = s.rs1; rs2_ID = s.rs2;
        use_rs1_ID = s.u1; use_rs2_ID = s.u2; redirect_MEM = s.redir; is_halt_MEM = s.halt_m;
    endtask

    task automatic do_reset();
        drive('0);
        nRST = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        drive('0);
        nRST = 1'b0;
        #1;
        vectors++;
        if (obs !== 8'h00) begin
            miscompares++; $display("FAIL reset_outputs: got %b want %b", obs, 8'h00);
        end
        vectors++;
        if (cycle_count !== '0 || stall_count !== '0) begin
            miscompares++; $display("FAIL reset_counters: got %0d/%0d want 0/0", cycle_count, stall_count);
        end
        @(negedge CLK);
        nRST = 1'b1;
        model_reset();
    endtask

    task automatic test_free_run();
        stim_t s; logic [7:0] e, mk;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            s = '0; s.ihit = 1'b1;
            drive(s); #1;
            e = model_out(s); mk = model_mask(s);
            vectors++;
            if ((obs & mk) !== (e & mk)) begin
                miscompares++; $display("FAIL free_run c%0d: got %b want %b", c, obs & mk, e & mk);
            end
            vectors++;
            if (!(pipeline_ctrl === 1'b1 && pc_en === 1'b1)) begin
                miscompares++; $display("FAIL free_run_adv c%0d: got ctl=%b pc_en=%b want 1/1", c, pipeline_ctrl, pc_en);
            end
            @(posedge CLK); model_clock(s); @(negedge CLK);
        end
        vectors++;
        if (cycle_count !== CNT_W'(5) || stall_count !== CNT_W'(0)) begin
            miscompares++; $display("FAIL free_run_counts: got %0d/%0d want 5/0", cycle_count, stall_count);
        end
    endtask

    task automatic test_dcache_wait();
        stim_t s; logic [7:0] e, mk;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            s = '0; s.mr_mem = 1'b1; s.ihit = (c == 0); s.dhit = (c == 3);
            drive(s); #1;
            e = model_out(s); mk = model_mask(s);
            vectors++;
            if ((obs & mk) !== (e & mk)) begin
                miscompares++; $display("FAIL dcache_wait c%0d: got %b want %b", c, obs & mk, e & mk);
            end
            vectors++;
            if (pipeline_ctrl !== (c == 3)) begin
                miscompares++; $display("FAIL dcache_wait_ctl c%0d: got %b want %b", c, pipeline_ctrl, (c == 3));
            end
            @(posedge CLK); model_clock(s); @(negedge CLK);
        end
        vectors++;
        if (stall_count !== CNT_W'(3) || cycle_count !== CNT_W'(4)) begin
            miscompares++; $display("FAIL dcache_wait_counts: got %0d/%0d want 4/3", cycle_count, stall_count);
        end
    endtask

    task automatic test_load_use();
        stim_t s;
        do_reset();
        s = '0; s.ihit = 1'b1; s.mr_ex = 1'b1; s.wsel = 5'd5; s.rs2 = 5'd5; s.u2 = 1'b1;
        s.rs1 = 5'd6; s.u1 = 1'b1;
        drive(s); #1;
        vectors++;
        if (obs !== 8'b1000_0100) begin
            miscompares++; $display("FAIL load_use_bubble: got %b want %b", obs, 8'b1000_0100);
        end
        @(posedge CLK); model_clock(s); @(negedge CLK);
        s.mr_ex = 1'b0;
        drive(s); #1;
        vectors++;
        if (obs !== 8'b1110_0000) begin
            miscompares++; $display("FAIL load_use_resume: got %b want %b", obs, 8'b1110_0000);
        end
        @(posedge CLK); model_clock(s); @(negedge CLK);
        // A load into x0 never creates a hazard.
        s.mr_ex = 1'b1; s.wsel = 5'd0; s.rs1 = 5'd0; s.rs2 = 5'd0;
        drive(s); #1;
        vectors++;
        if (obs !== 8'b1110_0000) begin
            miscompares++; $display("FAIL load_use_x0: got %b want %b", obs, 8'b1110_0000);
        end
        @(posedge CLK); model_clock(s); @(negedge CLK);
    endtask

    task automatic test_redirect();
        stim_t s;
        do_reset();
        s = '0; s.ihit = 1'b1; s.mr_ex = 1'b1; s.wsel = 5'd5; s.rs2 = 5'd5; s.u2 = 1'b1;
        s.redir = 1'b1;
        drive(s); #1;
        vectors++;
        if (obs !== 8'b1111_1110) begin
            miscompares++; $display("FAIL redirect_over_lu: got %b want %b", obs, 8'b1111_1110);
        end
        @(posedge CLK); model_clock(s); @(negedge CLK);
        vectors++;
        if (stall_count !== CNT_W'(0) || cycle_count !== CNT_W'(1)) begin
            miscompares++; $display("FAIL redirect_counts: got %0d/%0d want 1/0", cycle_count, stall_count);
        end
    endtask

    task automatic test_halt();
        stim_t s; logic [CNT_W-1:0] cc, sc;
        do_reset();
        s = '0; s.ihit = 1'b1; s.halt_m = 1'b1; s.redir = 1'b1;
        drive(s); #1;
        vectors++;
        if ({pipeline_ctrl, pc_en, pc_sel_redirect, flush_IF_ID, flush_ID_EX, flush_EX_MEM, halt} !== 7'b1001110) begin
            miscompares++;
            $display("FAIL halt_cycle: got %b want %b",
                     {pipeline_ctrl, pc_en, pc_sel_redirect, flush_IF_ID, flush_ID_EX, flush_EX_MEM, halt}, 7'b1001110);
        end
        @(posedge CLK); model_clock(s); @(negedge CLK);
        cc = cycle_count; sc = stall_count;
        vectors++;
        if (cc !== CNT_W'(1) || sc !== CNT_W'(0)) begin
            miscompares++; $display("FAIL halt_entry_counts: got %0d/%0d want 1/0", cc, sc);
        end
        for (int c = 0; c < 4; c++) begin
            s = '0; s.ihit = 1'b1; s.dhit = 1'b1; s.redir = c[0];
            drive(s); #1;
            vectors++;
            if (obs !== 8'b0000_0001) begin
                miscompares++; $display("FAIL halted_outputs c%0d: got %b want %b", c, obs, 8'b0000_0001);
            end
            @(posedge CLK); model_clock(s); @(negedge CLK);
        end
        vectors++;
        if (cycle_count !== cc || stall_count !== sc) begin
            miscompares++; $display("FAIL halted_frozen: got %0d/%0d want %0d/%0d", cycle_count, stall_count, cc, sc);
        end
    endtask

    task automatic test_saturation_and_reset();
        stim_t s; logic [7:0] e, mk;
        do_reset();
        for (int c = 0; c < CMAX + 3; c++) begin
            s = '0;
            drive(s); #1;
            e = model_out(s); mk = model_mask(s);
            vectors++;
            if ((obs & mk) !== (e & mk) || cycle_count !== CNT_W'(m_cycle) || stall_count !== CNT_W'(m_stall)) begin
                miscompares++;
                $display("FAIL saturate c%0d: got %b %0d/%0d want %b %0d/%0d",
                         c, obs & mk, cycle_count, stall_count, e & mk, m_cycle, m_stall);
            end
            @(posedge CLK); model_clock(s); @(negedge CLK);
        end
        vectors++;
        if (stall_count !== CNT_W'(CMAX) || cycle_count !== CNT_W'(CMAX)) begin
            miscompares++; $display("FAIL saturate_final: got %0d/%0d want %0d/%0d", cycle_count, stall_count, CMAX, CMAX);
        end
        // Park in IDONE: ihit taken while a load waits on the dcache.
        s = '0; s.ihit = 1'b1; s.mr_mem = 1'b1;
        drive(s);
        @(posedge CLK); model_clock(s); @(negedge CLK);
        drive('0);
        #2 nRST = 1'b0;
        #1;
        vectors++;
        if (obs !== 8'h00 || cycle_count !== '0 || stall_count !== '0) begin
            miscompares++; $display("FAIL reset_mid_wait: got %b %0d/%0d want %b 0/0", obs, cycle_count, stall_count, 8'h00);
        end
        @(negedge CLK);
        nRST = 1'b1;
        model_reset();
        #1;
        vectors++;
        if (pipeline_ctrl !== 1'b0) begin
            miscompares++; $display("FAIL reset_forgets_hit: got %b want 0", pipeline_ctrl);
        end
        @(negedge CLK);
        model_clock('0);
    endtask

    task automatic test_random();
        stim_t s; logic [7:0] e, mk;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 39) == 0) do_reset();
            s.ihit   = ($urandom_range(0, 1) == 1);
            s.dhit   = ($urandom_range(0, 1) == 1);
            s.mr_mem = ($urandom_range(0, 9) < 3);
            s.mw_mem = ($urandom_range(0, 9) < 2);
            s.mr_ex  = ($urandom_range(0, 9) < 4);
            s.wsel   = 5'($urandom_range(0, 3));
            s.rs1    = 5'($urandom_range(0, 3));
            s.rs2    = 5'($urandom_range(0, 3));
            s.u1     = ($urandom_range(0, 1) == 1);
            s.u2     = ($urandom_range(0, 1) == 1);
            s.redir  = ($urandom_range(0, 9) < 2);
            s.halt_m = ($urandom_range(0, 29) == 0);
            drive(s); #1;
            e = model_out(s); mk = model_mask(s);
            vectors++;
            if ((obs & mk) !== (e & mk)) begin
                miscompares++; $display("FAIL random_ctl c%0d: got %b want %b", c, obs & mk, e & mk);
            end
            vectors++;
            if (cycle_count !== CNT_W'(m_cycle) || stall_count !== CNT_W'(m_stall)) begin
                miscompares++;
                $display("FAIL random_cnt c%0d: got %0d/%0d want %0d/%0d", c, cycle_count, stall_count, m_cycle, m_stall);
            end
            @(posedge CLK); model_clock(s); @(negedge CLK);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_dcache_wait();
        test_load_use();
        test_redirect();
        test_halt();
        test_saturation_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
Central pipeline control for one core of the dual-core 5-stage RISC-V pipeline. Generates the global advance strobe (pipeline_ctrl) and the per-register flush/enable controls for IF/ID, ID/EX and EX/MEM. Covers cache-hit synchronisation, load-use bubbles, MEM-stage branch/jump redirects and halt. Keeps saturating cycle and stall counters for the performance harness.

Parameters:
CNT_W, 32, width of cycle_count and stall_count

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
ihit  in  1  icache hit, single-cycle pulse or level
dhit  in  1  dcache hit for current MEM access
MemRead_MEM  in  1  load pending in MEM
MemWr_MEM  in  1  store pending in MEM
MemRead_EX  in  1  instruction in EX is a load
wsel_EX  in  5  destination register of EX instruction
rs1_ID  in  5  source 1 of ID instruction
rs2_ID  in  5  source 2 of ID instruction
use_rs1_ID  in  1  ID instruction reads rs1
use_rs2_ID  in  1  ID instruction reads rs2
redirect_MEM  in  1  taken branch or jump resolved in MEM
is_halt_MEM  in  1  halt instruction in MEM
pipeline_ctrl  out  1  global advance strobe to all pipeline registers
pc_en  out  1  PC register write enable
ifid_en  out  1  IF/ID capture enable
pc_sel_redirect  out  1  PC mux selects MEM redirect target
flush_IF_ID  out  1  IF/ID loads bubble on advance
flush_ID_EX  out  1  ID/EX loads bubble on advance
flush_EX_MEM  out  1  EX/MEM loads bubble on advance
halt  out  1  core halted (registered)
cycle_count  out  CNT_W  cycles since reset, saturating
stall_count  out  CNT_W  non-halted cycles with pipeline_ctrl=0, saturating

Behaviour:
- Reset is asynchronous, active-low on nRST, clock CLK. On reset: state=FETCH, halt=0, both counters=0. All combinational outputs follow from FETCH with inputs low, so pipeline_ctrl=0, pc_en=0 and all flushes are 0 until ihit.
- FSM states: FETCH, IDONE, HALTED.
  - FETCH, ihit=1, d_ok=0 -> IDONE.
  - FETCH or IDONE, pipeline_ctrl=1: -> HALTED if is_halt_MEM, else -> FETCH.
  - IDONE holds until d_ok=1.
  - HALTED is absorbing until reset.
- Definitions:
  - d_req = MemRead_MEM | MemWr_MEM
  - d_ok = !d_req | dhit
  - i_ok = ihit | (state==IDONE)
- pipeline_ctrl = i_ok & d_ok & (state!=HALTED). Combinational, same cycle as the last hit.
- A dhit arriving before ihit is held by the EX/MEM register, which clears MemRead/MemWr_MEM. d_req therefore drops and d_ok stays 1. The sequencer does not latch dhit.
- Load-use: lu = MemRead_EX & wsel_EX!=0 & ((use_rs1_ID & rs1_ID==wsel_EX) | (use_rs2_ID & rs2_ID==wsel_EX)).
- Priority when pipeline_ctrl=1:
  1. redirect_MEM=1: pc_sel_redirect=1, pc_en=1, ifid_en=1, flush_IF_ID=flush_ID_EX=flush_EX_MEM=1. Overrides lu.
  2. else lu=1: pc_en=0, ifid_en=0, flush_ID_EX=1, other flushes 0. Exactly one bubble, because the load then moves to MEM and lu deasserts.
  3. else: pc_en=1, ifid_en=1, all flushes 0, pc_sel_redirect=0.
- When pipeline_ctrl=0: pc_en=0, ifid_en=0, all flushes 0, pc_sel_redirect=0.
- is_halt_MEM with pipeline_ctrl=1:
  - Same cycle: pc_en=0 and flush_IF_ID=flush_ID_EX=flush_EX_MEM=1.
  - Next cycle: halt=1 and state=HALTED.
  - Redirect does not override halt; halt has top priority.
- HALTED: all enables and flushes 0, halt=1, ihit/dhit ignored.
- Counters:
  - cycle_count increments every cycle while not HALTED.
  - stall_count increments when state!=HALTED and pipeline_ctrl=0.
  - Both saturate at all-ones and freeze in HALTED.
- Reset mid-wait (IDONE or HALTED) returns to FETCH with counters cleared. No hit is remembered across reset.

Test Plan:
1. Reset, ihit=1 and d_req=0 every cycle for 5 cycles -> pipeline_ctrl=1 and pc_en=1 each cycle; cycle_count=5, stall_count=0.
2. MemRead_MEM=1, ihit pulse in cycle 0, dhit in cycle 3 -> state IDONE in cycles 1-3; pipeline_ctrl=1 only in cycle 3; stall_count=3.
3. MemRead_EX=1, wsel_EX=5, rs2_ID=5, use_rs2_ID=1, hits present -> one cycle with pc_en=0, ifid_en=0, flush_ID_EX=1; next cycle (MemRead_EX=0) normal advance.
4. redirect_MEM=1 together with the load-use condition from scenario 3 -> pc_sel_redirect=1, pc_en=1, all three flushes=1, no stall.
5. is_halt_MEM=1 with hits -> flushes=1 and pc_en=0 that cycle; halt=1 next cycle; further ihit/dhit give pipeline_ctrl=0; counters frozen.
6. Force stall_count to all-ones-minus-1, stall 3 cycles -> saturates at all-ones. Assert nRST while IDONE -> immediate FETCH, halt=0, counters=0.
